// File: rtl/serializer_tx.sv
// rtl/serializer_tx.sv - parallel-to-serial transmitter with valid/ready intake and divided bit pacing
//
// Optional feature macro: SERIALIZER_TX_PARITY_EN (adds a trailing even-parity bit period)
//
// Parameters:
//    WIDTH     word width in bits (>= 2)
//    DIV       clock cycles per bit period (>= 1)
// Ports:
//    clk       clock, rising edge
//    rst       synchronous active-high reset
//    in_data   word to transmit, sampled on handshake
//    in_dir    bit order, 0 = MSB first, 1 = LSB first, sampled on handshake
//    in_valid  upstream has a word
//    in_ready  block can accept a word
//    sd        serial data bit
//    sen       one-cycle strobe marking sd valid downstream
//    sdir      latched in_dir for the downstream shift direction
//    sp        high while sd carries the parity bit
//    busy      high in SHIFT, PARITY and DONE
//    done      one-cycle pulse after the last bit
module serializer_tx #(
   parameter int WIDTH = 8,
   parameter int DIV   = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_dir,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             sd,
   output logic             sen,
   output logic             sdir,
   output logic             sp,
   output logic             busy,
   output logic             done
);

   localparam int BW = $clog2(WIDTH);
   localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

   if (WIDTH < 2 || DIV < 1) begin : g_bad_param
      $error("serializer_tx: WIDTH must be >= 2 and DIV must be >= 1");
   end

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
`ifdef SERIALIZER_TX_PARITY_EN
      PARITY = 2'd3,
`endif
      DONE   = 2'd2
   } state_t;

   state_t           state_q, state_n;
   logic [DW-1:0]    div_q, div_n;
   logic [BW-1:0]    bit_q, bit_n;
   logic [WIDTH-1:0] data_q, data_n;
   logic             dir_q, dir_n;
   logic [BW-1:0]    idx_n;
   logic             sd_n, sen_n, sp_n;

   // Next-state logic. Outputs are then derived from the next-state values
   // so every output is a flop that lines up with the state it describes.
   always_comb begin
      state_n = state_q;
      div_n   = div_q;
      bit_n   = bit_q;
      data_n  = data_q;
      dir_n   = dir_q;
      case (state_q)
         IDLE: begin
            if (in_valid && in_ready) begin
               state_n = SHIFT;
               data_n  = in_data;
               dir_n   = in_dir;
               div_n   = '0;
               bit_n   = '0;
            end
         end
         SHIFT: begin
            if (div_q == DIV_LAST) begin
               div_n = '0;
               if (bit_q == BIT_LAST) begin
                  bit_n = '0;
`ifdef SERIALIZER_TX_PARITY_EN
                  state_n = PARITY;
`else
                  state_n = DONE;
`endif
               end else begin
                  bit_n = bit_q + 1'b1;
               end
            end else begin
               div_n = div_q + 1'b1;
            end
         end
`ifdef SERIALIZER_TX_PARITY_EN
         PARITY: begin
            if (div_q == DIV_LAST) begin
               div_n   = '0;
               state_n = DONE;
            end else begin
               div_n = div_q + 1'b1;
            end
         end
`endif
         DONE: begin
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   // Output values for the coming cycle. The bit index walks up for LSB-first
   // and down for MSB-first; the strobe fires on the last divider cycle so the
   // bit has been stable for the whole period when the downstream stage takes it.
   always_comb begin
      idx_n = dir_n ? bit_n : (BIT_LAST - bit_n);
      sd_n  = 1'b0;
      sen_n = 1'b0;
      sp_n  = 1'b0;
      if (state_n == SHIFT) begin
         sd_n  = data_n[idx_n];
         sen_n = (div_n == DIV_LAST);
      end
`ifdef SERIALIZER_TX_PARITY_EN
      if (state_n == PARITY) begin
         sd_n  = ^data_n;
         sen_n = (div_n == DIV_LAST);
         sp_n  = 1'b1;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         div_q    <= '0;
         bit_q    <= '0;
         data_q   <= '0;
         dir_q    <= 1'b0;
         in_ready <= 1'b1;
         sd       <= 1'b0;
         sen      <= 1'b0;
         sdir     <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         state_q  <= state_n;
         div_q    <= div_n;
         bit_q    <= bit_n;
         data_q   <= data_n;
         dir_q    <= dir_n;
         in_ready <= (state_n == IDLE);
         sd       <= sd_n;
         sen      <= sen_n;
         sdir     <= dir_n;
         busy     <= (state_n != IDLE);
         done     <= (state_n == DONE);
      end
   end

`ifdef SERIALIZER_TX_PARITY_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         sp <= 1'b0;
      end else begin
         sp <= sp_n;
      end
   end
`else
   assign sp = 1'b0;
   logic unused_sp_n;
   assign unused_sp_n = sp_n;
`endif

endmodule

// File: tb/tb_serializer_tx.sv
// tb/tb_serializer_tx.sv - directed self-checking bench for serializer_tx
module tb_serializer_tx;

`ifdef SERIALIZER_TX_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif

   logic       clk;
   logic       rst;
   logic [7:0] d1, d3;
   logic       dir1, dir3, v1, v3;
   logic       rdy1, sd1, sen1, sdir1, sp1, busy1, done1;
   logic       rdy3, sd3, sen3, sdir3, sp3, busy3, done3;

   logic       sel;
   logic       m_rdy, m_sd, m_sen, m_sdir, m_sp, m_busy, m_done;

   int         nchk;
   int         nerr;

   logic [7:0] r_seq, r_sr;
   int         r_np, r_nsp, r_done, r_sdhi, r_badpos;
   logic       r_par, r_sdir;

   serializer_tx #(.WIDTH(8), .DIV(1)) u_dut1 (
      .clk(clk), .rst(rst), .in_data(d1), .in_dir(dir1), .in_valid(v1),
      .in_ready(rdy1), .sd(sd1), .sen(sen1), .sdir(sdir1), .sp(sp1),
      .busy(busy1), .done(done1)
   );

   serializer_tx #(.WIDTH(8), .DIV(3)) u_dut3 (
      .clk(clk), .rst(rst), .in_data(d3), .in_dir(dir3), .in_valid(v3),
      .in_ready(rdy3), .sd(sd3), .sen(sen3), .sdir(sdir3), .sp(sp3),
      .busy(busy3), .done(done3)
   );

   assign m_rdy  = sel ? rdy3  : rdy1;
   assign m_sd   = sel ? sd3   : sd1;
   assign m_sen  = sel ? sen3  : sen1;
   assign m_sdir = sel ? sdir3 : sdir1;
   assign m_sp   = sel ? sp3   : sp1;
   assign m_busy = sel ? busy3 : busy1;
   assign m_done = sel ? done3 : done1;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic s, input logic [7:0] d, input logic dir, input logic v);
      if (s) begin
         d3 = d; dir3 = dir; v3 = v;
      end else begin
         d1 = d; dir1 = dir; v1 = v;
      end
   endtask

   // Sends one word and records what a downstream shift register would see.
   // glitch != 0 scrambles in_data/in_dir at that cycle to show they are ignored.
   task automatic run_word(input logic s, input logic [7:0] d, input logic dir, input int glitch);
      int div;
      div      = s ? 3 : 1;
      sel      = s;
      r_seq    = '0;
      r_sr     = '0;
      r_np     = 0;
      r_nsp    = 0;
      r_par    = 1'b0;
      r_done   = 0;
      r_sdhi   = 0;
      r_badpos = 0;
      r_sdir   = 1'b0;
      @(negedge clk);
      drive(s, d, dir, 1'b1);
      for (int k = 0; k < 20 && !m_rdy; k++) @(negedge clk);
      @(posedge clk);
      #1;
      drive(s, d, dir, 1'b0);
      for (int t = 1; t <= 60; t++) begin
         @(negedge clk);
         if (t == glitch) drive(s, ~d, ~dir, 1'b0);
         if (m_sen) begin
            r_np++;
            if (t % div != 0) r_badpos++;
            if (m_sp) begin
               r_nsp++;
               r_par = m_sd;
            end else begin
               r_seq = {r_seq[6:0], m_sd};
               if (dir) r_sr = {m_sd, r_sr[7:1]};
               else     r_sr = {r_sr[6:0], m_sd};
            end
         end
         if (t <= 8 * div && m_sd) r_sdhi++;
         if (m_busy) r_sdir = m_sdir;
         if (m_done) begin
            r_done = t;
            break;
         end
      end
   endtask

   int hs[3];
   int nhs;
   int ndone;

   initial begin
      nchk = 0;
      nerr = 0;
      sel  = 1'b0;
      rst  = 1'b1;
      d1 = 8'hFF; dir1 = 1'b0; v1 = 1'b1;
      d3 = 8'h00; dir3 = 1'b0; v3 = 1'b0;

      // Reset held with in_valid high
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_in_ready", rdy1, 1);
      check("rst_sen", sen1, 0);
      check("rst_sd", sd1, 0);
      check("rst_busy", busy1, 0);
      check("rst_done", done1, 0);
      check("rst_sdir", sdir1, 0);
      check("rst_sp", sp1, 0);
      rst = 1'b0;
      v1  = 1'b0;
      @(negedge clk);
      check("rst_no_handshake", busy1, 0);

      // MSB first, inputs scrambled mid-word
      run_word(1'b0, 8'h1E, 1'b0, 3);
      check("msb_seq", r_seq, 8'h1E);
      check("msb_downstream", r_sr, 8'h1E);
      check("msb_pulses", r_np, 8 + PAR);
      check("msb_done_t", r_done, 9 + PAR);
      check("msb_sdir", r_sdir, 0);
      check("msb_sp_pulses", r_nsp, PAR);

      // LSB first
      run_word(1'b0, 8'h1E, 1'b1, 0);
      check("lsb_seq", r_seq, 8'h78);
      check("lsb_downstream", r_sr, 8'h1E);
      check("lsb_done_t", r_done, 9 + PAR);
      check("lsb_sdir", r_sdir, 1);
      @(negedge clk);
      check("idle_after_done", rdy1, 1);

      // DIV = 3, all ones
      run_word(1'b1, 8'hFF, 1'b0, 0);
      check("div3_pulses", r_np, 8 + PAR);
      check("div3_pulse_pos", r_badpos, 0);
      check("div3_sd_high", r_sdhi, 24);
      check("div3_done_t", r_done, 25 + 3 * PAR);
      check("div3_downstream", r_sr, 8'hFF);

      // Back-to-back handshakes with in_valid held high
      sel = 1'b0;
      nhs = 0;
      @(negedge clk);
      drive(1'b0, 8'h5A, 1'b0, 1'b1);
      for (int t = 0; t < 36; t++) begin
         if (rdy1 && nhs < 3) begin
            hs[nhs] = t;
            nhs++;
         end
         @(negedge clk);
      end
      drive(1'b0, 8'h5A, 1'b0, 1'b0);
      check("b2b_count", nhs, 3);
      check("b2b_gap1", hs[1] - hs[0], 10 + PAR);
      check("b2b_gap2", hs[2] - hs[1], 10 + PAR);
      for (int k = 0; k < 30 && !(rdy1 && !busy1); k++) @(negedge clk);
      check("b2b_drain", busy1, 0);

      // Reset mid-transfer at T4
      @(negedge clk);
      drive(1'b0, 8'hC3, 1'b0, 1'b1);
      @(posedge clk);
      #1;
      drive(1'b0, 8'hC3, 1'b0, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("abort_in_ready", rdy1, 1);
      check("abort_sen", sen1, 0);
      check("abort_busy", busy1, 0);
      ndone = 0;
      for (int k = 0; k < 15; k++) begin
         if (done1) ndone++;
         @(negedge clk);
      end
      check("abort_no_done", ndone, 0);
      run_word(1'b0, 8'hA5, 1'b0, 0);
      check("after_abort_seq", r_seq, 8'hA5);
      check("after_abort_done_t", r_done, 9 + PAR);

`ifdef SERIALIZER_TX_PARITY_EN
      run_word(1'b0, 8'h07, 1'b0, 0);
      check("par_pulses", r_np, 9);
      check("par_sp_pulses", r_nsp, 1);
      check("par_bit", r_par, 1);
      check("par_done_t", r_done, 10);
      check("par_seq", r_seq, 8'h07);
`endif

      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/serializer_tx.md
# serializer_tx

Parallel-to-serial transmitter that feeds the team's serial-in shift register stage. Accepts one WIDTH-bit word over a valid/ready handshake and emits it one bit per bit period on `sd`. It pulses `sen` once per bit and drives `sdir` so that the downstream shift register holds the original word, unreversed, after WIDTH pulses. It paces bits with a programmable clock divider and reports completion with a one-cycle `done` pulse.

## Interface
- WIDTH, 8: word width in bits; must be ≥ 2.
- DIV, 1: clock cycles per bit period; must be ≥ 1 (elaboration-time check fails the build otherwise).
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_data  input  WIDTH  word to transmit; sampled only on handshake.
- in_dir  input  1  bit order: 0 = MSB first, 1 = LSB first; sampled on handshake.
- in_valid  input  1  upstream has a word.
- in_ready  output  1  block can accept a word.
- sd  output  1  serial data bit.
- sen  output  1  one-cycle strobe marking `sd` valid for the downstream stage.
- sdir  output  1  latched `in_dir`; drives the downstream direction input.
- sp  output  1  high while the bit on `sd` is the parity bit.
- busy  output  1  high in SHIFT, PARITY and DONE.
- done  output  1  one-cycle pulse after the last bit.

## Operation
- States: IDLE, SHIFT, PARITY (only with the macro), DONE. All outputs are registered.
- Reset values: state IDLE, in_ready 1, sd 0, sen 0, sdir 0, sp 0, busy 0, done 0, counters 0.
- IDLE: in_ready=1, sd=0. A handshake (`in_valid && in_ready`) latches in_data and in_dir, clears the bit counter and the divider counter, and moves to SHIFT. in_valid without in_ready is ignored.
- SHIFT: sd = current bit, taken from MSB downward when dir=0 or from LSB upward when dir=1.
  - The divider counts 0..DIV-1; sen=1 in the cycle the divider equals DIV-1. The bit counter advances on that cycle.
  - After the WIDTH-th sen, go to PARITY if the macro is defined, else to DONE.
- PARITY: sd = even parity (XOR of all latched data bits), sp=1, lasts DIV cycles, one sen on the last cycle, then go to DONE.
- DONE: one cycle. done=1, in_ready=0, sd=0, sen=0, then go to IDLE.
- in_data and in_dir changes while busy have no effect. sdir holds its latched value until the next handshake.
- rst asserted in any state returns the block to reset values at the next edge and abandons the current word. in_valid is ignored while rst=1.
- Downstream contract: dir=0 shifts `sd` into the LSB and dir=1 shifts into the MSB. After WIDTH sen pulses the downstream register therefore equals the transmitted word for either order.

## Timing
- Handshake cycle is T0. SHIFT occupies T1..T(WIDTH·DIV). sen is high at T(k·DIV), k = 1..WIDTH.
- DONE is at T(WIDTH·DIV+1) without parity, or T((WIDTH+1)·DIV+1) with parity. in_ready returns high on the following cycle.
- Throughput, one word every WIDTH·DIV+2 cycles, or (WIDTH+1)·DIV+2 with parity. Example: WIDTH=8, DIV=1 gives 10 cycles.
- With DIV=1, sen is high every SHIFT cycle. `sd` is stable for the full bit period, DIV cycles.

## Configuration
- Macro SERIALIZER_TX_PARITY_EN.
- Defined: the PARITY state exists; each word produces WIDTH+1 sen pulses, the last with sp=1 and sd = even parity.
- Undefined: no PARITY state; WIDTH sen pulses per word; sp is tied to 0.

## Test plan
- Reset: hold rst 3 cycles with in_valid=1 → in_ready=1, sen=0, sd=0, busy=0, and no handshake occurs.
- WIDTH=8, DIV=1, in_data=8'h1E, in_dir=0 → sd on the sen cycles is 0,0,0,1,1,1,1,0; done at T9; a downstream shift register with dir=0 holds 8'h1E.
- Same word, in_dir=1 → sd sequence 0,1,1,1,1,0,0,0; downstream with dir=1 holds 8'h1E.
- DIV=3, in_data=8'hFF → sen pulses at T3, T6, …, T24; sd is high from T1 through T24; done at T25. Also hold in_valid=1 continuously with back-to-back words → handshakes exactly 10 cycles apart at DIV=1.
- Assert rst at T4 of a transfer → IDLE at the next edge with sen=0 and no done pulse; the next word transmits normally.
- With SERIALIZER_TX_PARITY_EN, in_data=8'h07 → 9 sen pulses, the ninth with sp=1 and sd=1; done at T10 (DIV=1).
